// File: rtl/hrz_peak_detect.sv
// hrz_peak_detect: snapshots the NF Goertzel results on the rising edge of
// "all channels valid", scans them one per cycle for the largest magnitude,
// then posts peak index / saturated |peak| and a threshold detection flag.
// Optional feature: define PEAK_HYST_EN to add hysteresis to det_o
// (assert above thresh, release only below thresh/2).
module hrz_peak_detect #(
    parameter  int NF = 2,
    parameter  int DW = 32,
    localparam int IW = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NF-1:0]          valid_i,
    input  logic [NF-1:0][DW-1:0]  data_arr_i,
    input  logic [DW-1:0]          thresh_i,
    input  logic                   clr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [IW-1:0]          peak_idx_o,
    output logic [DW-1:0]          peak_val_o,
    output logic                   det_o,
    output logic                   ovr_o
);

    typedef enum logic [1:0] {IDLE, SCAN, POST} state_t;

    localparam logic [IW-1:0] LAST = IW'(NF - 1);
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

    state_t                  state_q, state_d;
    logic                    all_v_q, all_v_d;
    logic [NF-1:0][DW-1:0]   snap_q, snap_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           max_q, max_d;
    logic [IW-1:0]           max_idx_q, max_idx_d;
    logic [IW-1:0]           peak_idx_q, peak_idx_d;
    logic [DW-1:0]           peak_val_q, peak_val_d;
    logic                    det_q, det_d;
    logic                    ovr_q, ovr_d;

    logic                    trig;
    logic [DW-1:0]           cur;
    logic [DW-1:0]           mag;
    logic                    gt;
    logic [DW-1:0]           max_n;
    logic [IW-1:0]           max_idx_n;

    // Magnitude of the channel under scan and the running max including it;
    // the last scan cycle posts max_n directly so channel NF-1 is counted.
    always_comb begin
        cur = snap_q[idx_q];
        if (!cur[DW-1])      mag = cur;
        else if (cur == SMIN) mag = SMAX;
        else                 mag = -cur;
        gt        = (mag > max_q);
        max_n     = gt ? mag   : max_q;
        max_idx_n = gt ? idx_q : max_idx_q;
    end

    // Next-state, scan datapath and posted outputs.
    always_comb begin
        state_d    = state_q;
        all_v_d    = &valid_i;
        snap_d     = snap_q;
        idx_d      = idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        peak_idx_d = peak_idx_q;
        peak_val_d = peak_val_q;
        det_d      = det_q;
        ovr_d      = ovr_q;

        trig = (&valid_i) & ~all_v_q;

        // Clear loses to a detection update landing on the same posting window.
        if (clr_i && state_q != POST) det_d = 1'b0;

        // Clear always beats a fresh overrun.
        if (clr_i)                          ovr_d = 1'b0;
        else if (trig && state_q != IDLE)   ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (trig) begin
                    snap_d    = data_arr_i;
                    idx_d     = '0;
                    max_d     = '0;
                    max_idx_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                max_d     = max_n;
                max_idx_d = max_idx_n;
                idx_d     = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    state_d    = POST;
                    peak_val_d = max_n;
                    peak_idx_d = max_idx_n;
`ifdef PEAK_HYST_EN
                    if (det_q) det_d = !(max_n < (thresh_i >> 1));
                    else       det_d = (max_n > thresh_i);
`else
                    det_d = (max_n > thresh_i);
`endif
                end
            end
            POST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            all_v_q    <= 1'b0;
            snap_q     <= '0;
            idx_q      <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            peak_idx_q <= '0;
            peak_val_q <= '0;
            det_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            all_v_q    <= all_v_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            peak_idx_q <= peak_idx_d;
            peak_val_q <= peak_val_d;
            det_q      <= det_d;
            ovr_q      <= ovr_d;
        end
    end

    assign busy_o     = (state_q == SCAN);
    assign done_o     = (state_q == POST);
    assign peak_idx_o = peak_idx_q;
    assign peak_val_o = peak_val_q;
    assign det_o      = det_q;
    assign ovr_o      = ovr_q;

endmodule

// File: tb/tb_hrz_peak_detect.sv
// Scoreboard bench for hrz_peak_detect (NF=2, DW=32). Expected posts are
// pushed when a trigger is driven and popped when done_o is seen.
`timescale 1ns/1ps
module tb_hrz_peak_detect;

    localparam int NF = 2;
    localparam int DW = 32;
    localparam int IW = 1;

    typedef logic [NF-1:0][DW-1:0] arr_t;
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
        logic          det;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [NF-1:0]  valid_i = '0;
    arr_t           data_arr_i = '0;
    logic [DW-1:0]  thresh_i = '0;
    logic           clr_i = 1'b0;
    logic           busy_o, done_o, det_o, ovr_o;
    logic [IW-1:0]  peak_idx_o;
    logic [DW-1:0]  peak_val_o;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic det_m = 1'b0;

    hrz_peak_detect #(.NF(NF), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_arr_i(data_arr_i),
        .thresh_i(thresh_i), .clr_i(clr_i), .busy_o(busy_o), .done_o(done_o),
        .peak_idx_o(peak_idx_o), .peak_val_o(peak_val_o), .det_o(det_o),
        .ovr_o(ovr_o)
    );

    always #5 clk = ~clk;

    // Reference: saturated magnitude, strict-greater scan, detection rule.
    task automatic push_exp(input arr_t d, input logic [DW-1:0] th);
        exp_t e;
        logic [DW-1:0] a, mx;
        int mi;
        mx = '0; mi = 0;
        for (int i = 0; i < NF; i++) begin
            if (d[i] == 32'h8000_0000) a = 32'h7FFF_FFFF;
            else if (d[i][DW-1])       a = -d[i];
            else                       a = d[i];
            if (a > mx) begin mx = a; mi = i; end
        end
`ifdef PEAK_HYST_EN
        if (det_m) det_m = (mx >= (th >> 1));
        else       det_m = (mx > th);
`else
        det_m = (mx > th);
`endif
        e.idx = IW'(mi); e.val = mx; e.det = det_m;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) e = 'x;
        else e = sb.pop_front();
    endtask

    // Drop valid for one edge, then raise it with new data; returns after edge E.
    task automatic fire(input arr_t d);
        @(negedge clk); valid_i = '0;
        @(negedge clk); data_arr_i = d; valid_i = '1; push_exp(d, thresh_i);
        @(posedge clk);
    endtask

    task automatic wait_done(output bit ok, output int cyc);
        ok = 0; cyc = 0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin ok = 1; cyc = i; end
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0; det_m = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy_o, done_o, peak_idx_o, peak_val_o, det_o, ovr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b idx=%0d val=%0h det=%b ovr=%b, want all 0",
                     busy_o, done_o, peak_idx_o, peak_val_o, det_o, ovr_o);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_basic();
        arr_t d; exp_t e;
        thresh_i = 100;
        d[0] = -32'sd500; d[1] = 32'sd300;
        fire(d);
        for (int i = 1; i <= NF + 1; i++) begin
            @(negedge clk);
            if (i == 1) data_arr_i = '1;   // bus may change after the snapshot
            vectors++;
            if ({busy_o, done_o} !== {1'(i <= NF), 1'(i == NF + 1)}) begin
                miscompares++;
                $display("FAIL basic_timing cyc%0d: busy/done=%b%b, want %b%b",
                         i, busy_o, done_o, 1'(i <= NF), 1'(i == NF + 1));
            end
        end
        pop_exp(e);
        vectors++;
        if ({peak_idx_o, peak_val_o, det_o} !== e ||
            peak_val_o !== 32'd500 || peak_idx_o !== 1'b0 || det_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_post: got idx=%0d val=%0d det=%b, want idx=0 val=500 det=1",
                     peak_idx_o, peak_val_o, det_o);
        end
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_width: done_o=%b one cycle later, want 0", done_o);
        end
        repeat (6) @(negedge clk);   // valid still high: no second trigger
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_level_held: busy=%b done=%b, want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_clear();
        do_clear();
        vectors++;
        if (det_o !== 1'b0 || ovr_o !== 1'b0) begin
            miscompares++;
            $display("FAIL clear: det=%b ovr=%b, want 0 0", det_o, ovr_o);
        end
    endtask

    task automatic test_tie_and_sat();
        arr_t d [2]; exp_t e; bit ok; int cyc;
        logic [DW-1:0] th [2];
        d[0][0] = -32'sd7; d[0][1] = 32'sd7;        th[0] = 10;
        d[1][0] = '0;      d[1][1] = 32'h8000_0000; th[1] = 10;
        for (int k = 0; k < 2; k++) begin
            thresh_i = th[k];
            fire(d[k]);
            wait_done(ok, cyc);
            pop_exp(e);
            vectors++;
            if (!ok || cyc != NF + 1 || {peak_idx_o, peak_val_o, det_o} !== e) begin
                miscompares++;
                $display("FAIL tie_sat[%0d]: ok=%0d lat=%0d idx=%0d val=%0h det=%b, want lat=%0d idx=%0d val=%0h det=%b",
                         k, ok, cyc, peak_idx_o, peak_val_o, det_o, NF + 1, e.idx, e.val, e.det);
            end
        end
    endtask

    task automatic test_overrun();
        arr_t a, b; exp_t e; bit ok; int cyc;
        thresh_i = 100;
        a[0] = 32'sd20; a[1] = -32'sd250;
        b[0] = 32'sd999; b[1] = 32'sd0;
        fire(a);
        @(negedge clk); valid_i = '0;
        @(negedge clk); valid_i = '1; data_arr_i = b;   // retrigger mid-scan
        wait_done(ok, cyc);
        pop_exp(e);
        vectors++;
        if (!ok || cyc != NF - 1 || {peak_idx_o, peak_val_o, det_o} !== e) begin
            miscompares++;
            $display("FAIL overrun_post: ok=%0d lat=%0d idx=%0d val=%0d det=%b, want lat=%0d idx=%0d val=%0d det=%b",
                     ok, cyc, peak_idx_o, peak_val_o, det_o, NF - 1, e.idx, e.val, e.det);
        end
        vectors++;
        if (ovr_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: ovr_o=%b, want 1", ovr_o);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || ovr_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_no_rescan: busy=%b done=%b ovr=%b, want 0 0 1", busy_o, done_o, ovr_o);
        end
        do_clear();
        vectors++;
        if (ovr_o !== 1'b0 || det_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: ovr=%b det=%b, want 0 0", ovr_o, det_o);
        end
    endtask

    task automatic test_back_to_back();
        arr_t a, b; exp_t e; bit ok; int cyc;
        thresh_i = 1000;
        a[0] = 32'sd5000; a[1] = 32'sd4000;
        b[0] = -32'sd10;  b[1] = -32'sd900;
        fire(a);
        for (int i = 1; i <= NF + 1; i++) begin
            @(negedge clk);
            if (i == 1) valid_i = '0;
        end
        pop_exp(e);
        vectors++;
        if (done_o !== 1'b1 || {peak_idx_o, peak_val_o, det_o} !== e) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b idx=%0d val=%0d det=%b, want 1 %0d %0d %b",
                     done_o, peak_idx_o, peak_val_o, det_o, e.idx, e.val, e.det);
        end
        @(negedge clk);   // next trigger NF+2 edges after the first
        data_arr_i = b; valid_i = '1; push_exp(b, thresh_i);
        wait_done(ok, cyc);
        pop_exp(e);
        vectors++;
        if (!ok || cyc != NF + 1 || {peak_idx_o, peak_val_o, det_o} !== e || ovr_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: ok=%0d lat=%0d idx=%0d val=%0d det=%b ovr=%b, want lat=%0d %0d %0d %b ovr=0",
                     ok, cyc, peak_idx_o, peak_val_o, det_o, ovr_o, NF + 1, e.idx, e.val, e.det);
        end
    endtask

    task automatic test_reset_mid_scan();
        arr_t a, b; exp_t e; bit ok; int cyc;
        thresh_i = 50;
        a[0] = 32'sd77; a[1] = 32'sd88;
        b[0] = -32'sd60; b[1] = 32'sd12;
        fire(a);
        @(negedge clk); rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy_o, done_o, peak_idx_o, peak_val_o, det_o, ovr_o} !== '0) begin
            miscompares++;
            $display("FAIL midscan_reset: busy=%b done=%b idx=%0d val=%0d det=%b ovr=%b, want all 0",
                     busy_o, done_o, peak_idx_o, peak_val_o, det_o, ovr_o);
        end
        sb.delete(); det_m = 1'b0;
        data_arr_i = b; push_exp(b, thresh_i);
        rstn = 1'b1;   // valid still high: retrigger on first edge after release
        wait_done(ok, cyc);
        pop_exp(e);
        vectors++;
        if (!ok || cyc != NF + 1 || {peak_idx_o, peak_val_o, det_o} !== e || ovr_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midscan_retrigger: ok=%0d lat=%0d idx=%0d val=%0d det=%b ovr=%b, want lat=%0d %0d %0d %b ovr=0",
                     ok, cyc, peak_idx_o, peak_val_o, det_o, ovr_o, NF + 1, e.idx, e.val, e.det);
        end
    endtask

    task automatic test_hysteresis();
        arr_t d; exp_t e; bit ok; int cyc;
        logic [DW-1:0] pk [3];
        logic [2:0] want;
        pk[0] = 150; pk[1] = 70; pk[2] = 40;
`ifdef PEAK_HYST_EN
        want = 3'b011;   // bit k = det after peak k
`else
        want = 3'b001;
`endif
        do_clear();
        thresh_i = 100;
        for (int k = 0; k < 3; k++) begin
            d[0] = pk[k]; d[1] = '0;
            fire(d);
            wait_done(ok, cyc);
            pop_exp(e);
            vectors++;
            if (!ok || {peak_idx_o, peak_val_o, det_o} !== e || det_o !== want[k]) begin
                miscompares++;
                $display("FAIL hyst[%0d]: ok=%0d val=%0d det=%b, want val=%0d det=%b",
                         k, ok, peak_val_o, det_o, pk[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        arr_t d; exp_t e; bit ok; int cyc;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NF; i++)
                d[i] = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            thresh_i = $urandom;
            fire(d);
            wait_done(ok, cyc);
            pop_exp(e);
            vectors++;
            if (!ok || cyc != NF + 1 || {peak_idx_o, peak_val_o, det_o} !== e) begin
                miscompares++;
                $display("FAIL random[%0d]: ok=%0d lat=%0d idx=%0d val=%0h det=%b, want %0d %0h %b",
                         k, ok, cyc, peak_idx_o, peak_val_o, det_o, e.idx, e.val, e.det);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_tie_and_sat();
        test_overrun();
        test_back_to_back();
        test_reset_mid_scan();
        test_hysteresis();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
